// File: rtl/lift_call_panel.sv
// Call front end for the 3-floor lift: synchronise, debounce, latch and clear the seven request lines.
// Build option: define DEBOUNCE_EN to include the per-button debounce FSM; otherwise the synchroniser drives the latch directly.
module lift_call_panel #(
  parameter int DB_CYCLES = 4,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_flr1,
  input  logic       btn_flr2,
  input  logic       btn_flr3,
  input  logic       btn_up1,
  input  logic       btn_up2,
  input  logic       btn_dw2,
  input  logic       btn_dw3,
  input  logic [2:0] lift_state,
  output logic       flr1,
  output logic       flr2,
  output logic       flr3,
  output logic       up1,
  output logic       up2,
  output logic       dw2,
  output logic       dw3,
  output logic [2:0] req_cnt
);

  localparam int NB = 7;

  localparam logic [2:0] OPEN1 = 3'b000;
  localparam logic [2:0] OPEN2 = 3'b011;
  localparam logic [2:0] OPEN3 = 3'b101;

  // Request bit order: {dw3, dw2, up2, up1, flr3, flr2, flr1}
  localparam logic [NB-1:0] FLOOR1_MASK = 7'b0001001;
  localparam logic [NB-1:0] FLOOR2_MASK = 7'b0110010;
  localparam logic [NB-1:0] FLOOR3_MASK = 7'b1000100;

  if (DB_CYCLES < 1 || DB_CYCLES > 15 || DB_CYCLES >= (1 << CW)) begin : g_bad_db
    $error("lift_call_panel: DB_CYCLES must be 1..15 and below 2**CW");
  end

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] level;
  logic [NB-1:0] level_q;
  logic [NB-1:0] armed;
  logic [NB-1:0] rise;
  logic [NB-1:0] clr;
  logic [NB-1:0] req;
  logic [NB-1:0] req_next;
  logic [2:0]    cnt_next;
  logic [1:0]    warm;

  assign raw = {btn_dw3, btn_dw2, btn_up2, btn_up1, btn_flr3, btn_flr2, btn_flr1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  typedef enum logic [1:0] {D_LOW, D_RISE, D_HIGH, D_FALL} db_state_t;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  for (genvar i = 0; i < NB; i++) begin : g_db
    db_state_t     state;
    logic [CW-1:0] cnt;
    logic          lvl;

    // The level only flips after DB_CYCLES consecutive samples disagree with it
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= D_LOW;
        cnt   <= '0;
        lvl   <= 1'b0;
      end else begin
        case (state)
          D_LOW: begin
            if (sync2[i]) begin
              if (DB_CYCLES == 1) begin
                state <= D_HIGH;
                lvl   <= 1'b1;
                cnt   <= '0;
              end else begin
                state <= D_RISE;
                cnt   <= CNT_ONE;
              end
            end
          end
          D_RISE: begin
            if (!sync2[i]) begin
              state <= D_LOW;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= D_HIGH;
              lvl   <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          D_HIGH: begin
            if (!sync2[i]) begin
              if (DB_CYCLES == 1) begin
                state <= D_LOW;
                lvl   <= 1'b0;
                cnt   <= '0;
              end else begin
                state <= D_FALL;
                cnt   <= CNT_ONE;
              end
            end
          end
          D_FALL: begin
            if (sync2[i]) begin
              state <= D_HIGH;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= D_LOW;
              lvl   <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= D_LOW;
            cnt   <= '0;
            lvl   <= 1'b0;
          end
        endcase
      end
    end

    assign level[i] = lvl;
  end
`else
  assign level = sync2;
`endif

  // A button only becomes latchable once it has been seen released after reset,
  // so buttons held through a reset do not re-raise requests. warm waits until
  // the synchroniser holds genuine post-reset samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      armed   <= '0;
      warm    <= '0;
    end else begin
      level_q <= level;
      if (warm != 2'd2) begin
        warm <= warm + 2'd1;
      end else begin
        armed <= armed | ~sync2;
      end
    end
  end

  assign rise = level & ~level_q & armed;

  always_comb begin
    clr = '0;
    case (lift_state)
      OPEN1:   clr = FLOOR1_MASK;
      OPEN2:   clr = FLOOR2_MASK;
      OPEN3:   clr = FLOOR3_MASK;
      default: clr = '0;
    endcase
  end

  // Clear dominates set so presses at an open floor are absorbed
  assign req_next = (req | rise) & ~clr;

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_next = cnt_next + {2'b00, req_next[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req     <= '0;
      req_cnt <= '0;
    end else begin
      req     <= req_next;
      req_cnt <= cnt_next;
    end
  end

  assign flr1 = req[0];
  assign flr2 = req[1];
  assign flr3 = req[2];
  assign up1  = req[3];
  assign up2  = req[4];
  assign dw2  = req[5];
  assign dw3  = req[6];

endmodule

// File: tb/tb_lift_call_panel.sv
// Testbench for lift_call_panel: directed scenarios plus randomized button/lift traffic against a sample-history model.
// Builds with or without DEBOUNCE_EN; expected latencies follow the macro.
module tb_lift_call_panel;

  localparam int DB = 4;
`ifdef DEBOUNCE_EN
  localparam int LAT    = 3 + DB;
  localparam int GLITCH = 0;
`else
  localparam int LAT    = 3;
  localparam int GLITCH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] btn;
  logic [2:0] lift_state;
  logic       flr1, flr2, flr3, up1, up2, dw2, dw3;
  logic [2:0] req_cnt;
  logic [6:0] dut_req;

  int vectors     = 0;
  int miscompares = 0;

  assign dut_req = {dw3, dw2, up2, up1, flr3, flr2, flr1};

  lift_call_panel #(.DB_CYCLES(DB), .CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_flr1   (btn[0]),
    .btn_flr2   (btn[1]),
    .btn_flr3   (btn[2]),
    .btn_up1    (btn[3]),
    .btn_up2    (btn[4]),
    .btn_dw2    (btn[5]),
    .btn_dw3    (btn[6]),
    .lift_state (lift_state),
    .flr1       (flr1),
    .flr2       (flr2),
    .flr3       (flr3),
    .up1        (up1),
    .up2        (up2),
    .dw2        (dw2),
    .dw3        (dw3),
    .req_cnt    (req_cnt)
  );

  always #5 clk = ~clk;

  // Model: floor served by each request line, in dut_req bit order
  int btn_floor [7] = '{1, 2, 3, 1, 2, 2, 3};

  bit hist [7][$];
  bit lvl  [7][$];
  bit m_req [7];
  int first_low [7];
  int e;
  bit [6:0] m_exp;
  int m_cnt;

  function automatic int open_floor(input logic [2:0] ls);
    case (ls)
      3'b000:  return 1;
      3'b011:  return 2;
      3'b101:  return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit sample_at(input int b, input int k);
    if (k < 1 || k > hist[b].size()) return 1'b0;
    return hist[b][k-1];
  endfunction

  task automatic model_reset();
    e = 0;
    for (int b = 0; b < 7; b++) begin
      hist[b].delete();
      lvl[b].delete();
      lvl[b].push_back(1'b0);
      m_req[b]     = 1'b0;
      first_low[b] = 1 << 30;
    end
  endtask

  // Edge e: sample k is the raw value taken at edge k; a press is honoured only
  // after some post-reset sample was low, and only on a debounced 0->1 change.
  task automatic model_edge(input logic [6:0] raw, input logic [2:0] ls);
    bit cur, nxt, prev2, set, stable;
    e++;
    for (int b = 0; b < 7; b++) begin
      hist[b].push_back(raw[b]);
      if (raw[b] == 1'b0 && first_low[b] > e) first_low[b] = e;
      cur = lvl[b][e-1];
`ifdef DEBOUNCE_EN
      stable = 1'b1;
      for (int j = 0; j < DB; j++) begin
        if (sample_at(b, e - 2 - j) == cur) stable = 1'b0;
      end
      nxt = stable ? !cur : cur;
`else
      stable = 1'b0;
      nxt = sample_at(b, e - 1);
`endif
      lvl[b].push_back(nxt);
      prev2 = (e >= 2) ? lvl[b][e-2] : 1'b0;
      set   = cur && !prev2 && (first_low[b] <= e - 3);
      if (open_floor(ls) == btn_floor[b]) m_req[b] = 1'b0;
      else if (set)                       m_req[b] = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_edge(btn, lift_state);
      #1;
      m_cnt = 0;
      for (int b = 0; b < 7; b++) begin
        m_exp[b] = m_req[b];
        m_cnt += int'(m_req[b]);
      end
      vectors++;
      if (dut_req !== m_exp || req_cnt !== 3'(m_cnt)) begin
        miscompares++;
        $display("[TB] FAIL cycle_compare t=%0t req=%b cnt=%0d, expected req=%b cnt=%0d",
                 $time, dut_req, req_cnt, m_exp, m_cnt);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] b, input logic [2:0] ls);
    @(negedge clk);
    btn        = b;
    lift_state = ls;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clearAll();
    applyStimulus(7'b0, 3'b000); hold(1);
    applyStimulus(7'b0, 3'b011); hold(1);
    applyStimulus(7'b0, 3'b101); hold(1);
    applyStimulus(7'b0, 3'b001);
  endtask

  initial begin
    rst        = 1'b1;
    btn        = 7'b0;
    lift_state = 3'b001;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_req", int'(dut_req), 0);
    checkOutput("reset_cnt", int'(req_cnt), 0);
    @(negedge clk) rst = 1'b0;
    hold(6);

    $display("[TB] hall up press on floor 2, latency and hold");
    applyStimulus(7'b0010000, 3'b001);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #2;
      if (k == LAT - 1) checkOutput("up2_pre_latency", int'(up2), 0);
      if (k == LAT) begin
        checkOutput("up2_at_latency", int'(up2), 1);
        checkOutput("up2_req_cnt", int'(req_cnt), 1);
      end
    end
    applyStimulus(7'b0, 3'b001);
    hold(LAT + 3); #2;
    checkOutput("up2_after_release", int'(up2), 1);

    $display("[TB] two-cycle glitch on flr3");
    clearAll();
    applyStimulus(7'b0000100, 3'b001);
    hold(2);
    applyStimulus(7'b0, 3'b001);
    @(posedge clk); #2;
    checkOutput("flr3_glitch_edge3", int'(flr3), GLITCH);
    hold(8); #2;
    checkOutput("flr3_glitch_late", int'(flr3), GLITCH);

    $display("[TB] open at floor 1 clears only floor 1");
    clearAll();
    applyStimulus(7'b0001011, 3'b001);
    hold(LAT + 2);
    applyStimulus(7'b0, 3'b001);
    hold(LAT + 3); #2;
    checkOutput("three_pending_cnt", int'(req_cnt), 3);
    applyStimulus(7'b0, 3'b000);
    #1;
    checkOutput("flr1_before_clear_edge", int'(flr1), 1);
    @(posedge clk); #2;
    checkOutput("open1_clears", int'({flr1, up1, flr2}), 1);
    checkOutput("open1_cnt", int'(req_cnt), 1);
    applyStimulus(7'b0, 3'b001);

    $display("[TB] press absorbed while open at floor 3");
    clearAll();
    applyStimulus(7'b1000000, 3'b101);
    hold(10); #2;
    checkOutput("dw3_absorbed_open", int'(dw3), 0);
    applyStimulus(7'b1000000, 3'b100);
    hold(10); #2;
    checkOutput("dw3_held_after_close", int'(dw3), 0);
    applyStimulus(7'b0, 3'b100);
    hold(LAT + 3);

    $display("[TB] simultaneous presses at open floor 2, then invalid codes");
    clearAll();
    applyStimulus(7'b0000011, 3'b011);
    hold(LAT + 1); #2;
    checkOutput("open2_flr2_absorbed", int'(flr2), 0);
    checkOutput("open2_flr1_set", int'(flr1), 1);
    applyStimulus(7'b0, 3'b011);
    hold(LAT + 3);
    applyStimulus(7'h7F, 3'b111);
    hold(LAT + 1);
    applyStimulus(7'b0, 3'b111);
    hold(LAT + 3); #2;
    checkOutput("invalid_all_pending", int'(dut_req), 127);
    checkOutput("invalid_cnt7", int'(req_cnt), 7);
    applyStimulus(7'b0, 3'b110);
    hold(3); #2;
    checkOutput("invalid110_cnt7", int'(req_cnt), 7);

    $display("[TB] asynchronous reset with all buttons held");
    applyStimulus(7'h7F, 3'b001);
    hold(4);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_reset_req", int'(dut_req), 0);
    checkOutput("async_reset_cnt", int'(req_cnt), 0);
    @(negedge clk) rst = 1'b0;
    hold(LAT + 6); #2;
    checkOutput("held_through_reset", int'(dut_req), 0);
    applyStimulus(7'b0, 3'b001);
    hold(LAT + 3); #2;
    checkOutput("released_after_reset", int'(dut_req), 0);
    applyStimulus(7'h7F, 3'b001);
    hold(LAT + 1); #2;
    checkOutput("repress_after_reset", int'(dut_req), 127);
    applyStimulus(7'b0, 3'b001);
    hold(LAT + 3);
    clearAll();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      logic [6:0] nb;
      logic [2:0] nls;
      nb = btn;
      for (int b = 0; b < 7; b++) begin
        if ($urandom_range(0, 9) == 0) nb[b] = ~nb[b];
      end
      nls = lift_state;
      if ($urandom_range(0, 7) == 0) nls = 3'($urandom_range(0, 7));
      applyStimulus(nb, nls);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    hold(2);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
